// File: rtl/pc_unit.sv
// Program-counter unit: fetch PC, branch-condition evaluation, next-PC select.
// Latency: selection is registered, so the next PC appears on o_pc one edge later; o_taken/o_pc_plus2 are combinational.
// Backpressure: i_stall holds PC and state for the cycle; HALTED freezes the unit until reset (or redirect, if enabled).
//
// Optional feature macro: PC_REDIRECT_EN adds i_redirect / i_redirect_addr,
// an external redirect that overrides stall, halt and HALTED.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_stall               hold PC and state this cycle
//   i_branch              PC-relative conditional branch in decode
//   i_branch_reg          register-indirect conditional branch in decode
//   i_cond                3-bit condition code
//   i_imm                 signed halfword offset for relative branches
//   i_reg_target          absolute target for register-indirect branches
//   i_flag_z/n/v          current flags
//   i_halt                halt instruction in decode
//   i_redirect(_addr)     external redirect (PC_REDIRECT_EN only)
//   o_pc                  registered current PC
//   o_pc_plus2            pc + 2 (link value)
//   o_taken               a branch is taken this cycle
//   o_halted              unit is in HALTED
module pc_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                IMM_W    = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_branch,
  input  logic              i_branch_reg,
  input  logic [2:0]        i_cond,
  input  logic [IMM_W-1:0]  i_imm,
  input  logic [ADDR_W-1:0] i_reg_target,
  input  logic              i_flag_z,
  input  logic              i_flag_n,
  input  logic              i_flag_v,
  input  logic              i_halt,
`ifdef PC_REDIRECT_EN
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_addr,
`endif
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus2,
  output logic              o_taken,
  output logic              o_halted
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;

  logic              w_cond_true;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_pc_plus2;
  logic [ADDR_W-1:0] w_imm_ext;
  logic [ADDR_W-1:0] w_rel_target;
  logic [ADDR_W-1:0] w_reg_target;
  logic [ADDR_W-1:0] w_even_mask;

  // Targets are halfword aligned; bit 0 is always cleared.
  assign w_even_mask = ~{{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef PC_REDIRECT_EN
  logic [ADDR_W-1:0] w_redirect_target;
  assign w_redirect        = i_redirect;
  assign w_redirect_target = i_redirect_addr & w_even_mask;
`else
  assign w_redirect = 1'b0;
`endif

  always_comb begin
    w_cond_true = 1'b0;
    case (i_cond)
      3'b000:  w_cond_true = ~i_flag_z;               // NE
      3'b001:  w_cond_true = i_flag_z;                // EQ
      3'b010:  w_cond_true = ~i_flag_z & ~i_flag_n;   // GT
      3'b011:  w_cond_true = i_flag_n;                // LT
      3'b100:  w_cond_true = i_flag_z | ~i_flag_n;    // GE
      3'b101:  w_cond_true = i_flag_z | i_flag_n;     // LE
      3'b110:  w_cond_true = i_flag_v;                // OV
      default: w_cond_true = 1'b1;                    // always
    endcase
  end

  assign w_pc_plus2   = r_pc + ADDR_W'(2);
  assign w_imm_ext    = {{(ADDR_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
  // Offset is in halfwords; wraps modulo 2^ADDR_W.
  assign w_rel_target = w_pc_plus2 + (w_imm_ext << 1);
  assign w_reg_target = i_reg_target & w_even_mask;

  // Forced low during reset, stall, HALTED and redirect so downstream
  // link/flush logic never sees a phantom branch.
  assign o_taken = (i_branch | i_branch_reg) & w_cond_true & ~i_stall &
                   (r_state == ST_RUN) & ~i_rst & ~w_redirect;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc    <= RESET_PC;
      r_state <= ST_RUN;
    end else begin
`ifdef PC_REDIRECT_EN
      if (w_redirect) begin
        r_pc    <= w_redirect_target;
        r_state <= ST_RUN;
      end else
`endif
      begin
        case (r_state)
          ST_RUN: begin
            if (!i_stall) begin
              if (i_halt) begin
                // PC keeps the halt instruction's address.
                r_state <= ST_HALTED;
              end else if (o_taken && i_branch_reg) begin
                r_pc <= w_reg_target;
              end else if (o_taken) begin
                r_pc <= w_rel_target;
              end else begin
                r_pc <= w_pc_plus2;
              end
            end
          end
          default: begin
            r_pc    <= r_pc;
            r_state <= ST_HALTED;
          end
        endcase
      end
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus2 = w_pc_plus2;
  assign o_halted   = (r_state == ST_HALTED);

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch;
  logic        branch_reg;
  logic [2:0]  cond;
  logic [8:0]  imm;
  logic [15:0] reg_target;
  logic        flag_z;
  logic        flag_n;
  logic        flag_v;
  logic        halt;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        taken;
  logic        halted;
`ifdef PC_REDIRECT_EN
  logic        redirect;
  logic [15:0] redirect_addr;
`endif

  int errors = 0;
  int checks = 0;

  pc_unit #(
    .ADDR_W  (16),
    .IMM_W   (9),
    .RESET_PC(16'h0100)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_stall        (stall),
    .i_branch       (branch),
    .i_branch_reg   (branch_reg),
    .i_cond         (cond),
    .i_imm          (imm),
    .i_reg_target   (reg_target),
    .i_flag_z       (flag_z),
    .i_flag_n       (flag_n),
    .i_flag_v       (flag_v),
    .i_halt         (halt),
`ifdef PC_REDIRECT_EN
    .i_redirect     (redirect),
    .i_redirect_addr(redirect_addr),
`endif
    .o_pc           (pc),
    .o_pc_plus2     (pc_plus2),
    .o_taken        (taken),
    .o_halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] start_pc;
    logic        br;
    logic        br_reg;
    logic        stl;
    logic [2:0]  cc;
    logic [2:0]  znv;
    logic [8:0]  off;
    logic [15:0] tgt;
    logic        exp_taken;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Condition table written as a lookup against ZNV = {z,n,v}.
  function automatic logic cond_ref(input logic [2:0] c, input logic [2:0] znv);
    logic z, n, v;
    z = znv[2]; n = znv[1]; v = znv[0];
    if (c == 3'd0) return !z;
    if (c == 3'd1) return z;
    if (c == 3'd2) return !(z || n);
    if (c == 3'd3) return n;
    if (c == 3'd4) return z || !n;
    if (c == 3'd5) return z || n;
    if (c == 3'd6) return v;
    return 1'b1;
  endfunction

  task automatic clear_inputs();
    stall = 0; branch = 0; branch_reg = 0; cond = 0; imm = 0;
    reg_target = 0; flag_z = 0; flag_n = 0; flag_v = 0; halt = 0;
`ifdef PC_REDIRECT_EN
    redirect = 0; redirect_addr = 0;
`endif
  endtask

  // Load an arbitrary PC through an unconditional register-indirect branch.
  task automatic set_pc(input logic [15:0] a);
    @(negedge clk);
    clear_inputs();
    branch_reg = 1; cond = 3'b111; reg_target = a;
    @(posedge clk); #1;
    clear_inputs();
    chk("set_pc", {16'h0, pc}, {16'h0, a});
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    #1 rst = 1;
    #2;
    chk("reset_pc", {16'h0, pc}, 32'h0100);
    chk("reset_halted", {31'h0, halted}, 0);
    branch = 1; cond = 3'b111;
    #1;
    chk("reset_taken", {31'h0, taken}, 0);
    @(posedge clk); #1;
    chk("reset_hold_pc", {16'h0, pc}, 32'h0100);
    @(negedge clk);
    clear_inputs();
    rst = 0;
    #1;
    chk("idle0_pc", {16'h0, pc}, 32'h0100);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk("idle_pc", {16'h0, pc}, 32'h0100 + 2 * i);
      chk("idle_halted", {31'h0, halted}, 0);
    end

    // start, br, br_reg, stall, cond, znv, imm, reg_target, exp_taken, exp_pc
    vecs[0] = '{16'h0200, 1, 0, 0, 3'b001, 3'b100, 9'h1FE, 16'h0000, 1, 16'h01FE};
    vecs[1] = '{16'h0200, 1, 0, 0, 3'b001, 3'b000, 9'h1FE, 16'h0000, 0, 16'h0202};
    vecs[2] = '{16'hFFFE, 0, 0, 0, 3'b111, 3'b000, 9'h000, 16'h0000, 0, 16'h0000};
    vecs[3] = '{16'hFFFE, 1, 0, 0, 3'b111, 3'b000, 9'h001, 16'h0000, 1, 16'h0002};
    vecs[4] = '{16'h0300, 1, 0, 1, 3'b111, 3'b000, 9'h010, 16'h0000, 0, 16'h0300};
    vecs[5] = '{16'h0600, 1, 1, 0, 3'b111, 3'b000, 9'h010, 16'h1235, 1, 16'h1234};
    vecs[6] = '{16'h0500, 0, 1, 0, 3'b000, 3'b100, 9'h000, 16'h2000, 0, 16'h0502};
    vecs[7] = '{16'h1000, 1, 0, 0, 3'b110, 3'b001, 9'h0FF, 16'h0000, 1, 16'h1200};
    vecs[8] = '{16'h1000, 1, 0, 0, 3'b111, 3'b000, 9'h100, 16'h0000, 1, 16'h0E02};

    for (int k = 0; k < 9; k++) begin
      set_pc(vecs[k].start_pc);
      @(negedge clk);
      branch = vecs[k].br; branch_reg = vecs[k].br_reg; stall = vecs[k].stl;
      cond = vecs[k].cc; flag_z = vecs[k].znv[2]; flag_n = vecs[k].znv[1];
      flag_v = vecs[k].znv[0]; imm = vecs[k].off; reg_target = vecs[k].tgt;
      #1;
      chk($sformatf("vec%0d_taken", k), {31'h0, taken}, {31'h0, vecs[k].exp_taken});
      chk($sformatf("vec%0d_plus2", k), {16'h0, pc_plus2}, {16'h0, vecs[k].start_pc + 16'd2});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_pc", k), {16'h0, pc}, {16'h0, vecs[k].exp_pc});
      clear_inputs();
    end

    // Condition sweep: all codes against all flag combinations.
    @(negedge clk);
    clear_inputs();
    branch = 1;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        cond = c[2:0]; flag_z = f[2]; flag_n = f[1]; flag_v = f[0];
        #0.5;
        chk($sformatf("cond%0d_znv%0d", c, f), {31'h0, taken}, {31'h0, cond_ref(c[2:0], f[2:0])});
        #0.1;
      end
    end
    clear_inputs();

    // halt while stalled must not halt.
    set_pc(16'h0800);
    @(negedge clk);
    stall = 1; halt = 1;
    @(posedge clk); #1;
    chk("stall_halt_halted", {31'h0, halted}, 0);
    chk("stall_halt_pc", {16'h0, pc}, 32'h0800);
    clear_inputs();
    @(posedge clk); #1;
    chk("after_stall_pc", {16'h0, pc}, 32'h0802);

    // halt, then ten cycles of branch attempts.
    set_pc(16'h0700);
    @(negedge clk);
    halt = 1;
    @(posedge clk); #1;
    chk("halt_halted", {31'h0, halted}, 1);
    chk("halt_pc", {16'h0, pc}, 32'h0700);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      clear_inputs();
      branch = 1; branch_reg = i[0]; cond = 3'b111;
      imm = 9'($urandom_range(0, 511)); reg_target = 16'h4444;
      #1;
      chk("halted_taken", {31'h0, taken}, 0);
      @(posedge clk); #1;
      chk("halted_pc", {16'h0, pc}, 32'h0700);
      chk("halted_flag", {31'h0, halted}, 1);
    end

`ifdef PC_REDIRECT_EN
    @(negedge clk);
    clear_inputs();
    redirect = 1; redirect_addr = 16'h0401; stall = 1; branch = 1; cond = 3'b111;
    #1;
    chk("redirect_taken", {31'h0, taken}, 0);
    @(posedge clk); #1;
    chk("redirect_pc", {16'h0, pc}, 32'h0400);
    chk("redirect_halted", {31'h0, halted}, 0);
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
    chk("post_redirect_pc", {16'h0, pc}, 32'h0402);
    @(negedge clk);
    halt = 1;
    @(posedge clk); #1;
    clear_inputs();
    chk("rehalt", {31'h0, halted}, 1);
`endif

    // Asynchronous reset mid-cycle from HALTED.
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_pc", {16'h0, pc}, 32'h0100);
    chk("async_rst_halted", {31'h0, halted}, 0);
    @(negedge clk);
    clear_inputs();
    rst = 0;
    @(posedge clk); #1;
    chk("post_rst_pc", {16'h0, pc}, 32'h0102);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
